// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and counter sizing for the FIFO-draining UART transmitter
//
// Purpose : state enumeration used by fifo_uart_tx, default baud divisor and the
//           helper that derives counter widths from a count range.
// Ports   : none (package).
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_e;

  // 100 MHz system clock, 115200 baud
  localparam int unsigned CLKS_PER_BIT_DFLT = 868;

  // Width needed to hold 0..n-1; never below one bit so n=1 or n=2 still
  // produce a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BIT_CNT_W_DFLT = cnt_width(CLKS_PER_BIT_DFLT);

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period timer producing a tick on the last cycle of every bit
//
// Purpose : counts 0..CLKS_PER_BIT-1 and wraps; clear restarts the bit period
//           so the first bit after a load is a full period.
// Ports   : clk        - system clock, rising edge
//           rst        - asynchronous active-low reset
//           clr_i      - restart the bit period (counter reads 0 next cycle)
//           bit_tick_o - high on the last cycle of each bit period
//           bit_pre_o  - high on the second-to-last cycle of each bit period
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_tick_o,
  output logic bit_pre_o
);

  localparam int unsigned       CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The pre-tick lets the caller register an output that must be high on the
  // final cycle of a bit rather than one cycle after it.
  assign bit_tick_o = (cnt_q == CNT_LAST) && !clr_i;
  assign bit_pre_o  = (cnt_q == CNT_PRE)  && !clr_i;

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains an upstream FIFO word by word onto an 8N1-style UART line
//
// Purpose : reads one word per frame from a registered-output FIFO and sends it
//           as start bit, DATA_WIDTH data bits LSB first, stop bit.
// Ports   : clk        - system clock, rising edge
//           rst        - asynchronous active-low reset
//           enable     - drain permission, looked at only when choosing to start a frame
//           fifo_empty - upstream FIFO empty flag
//           fifo_data  - upstream read data, valid the cycle after fifo_rd_en
//           fifo_rd_en - one-cycle read strobe
//           tx         - serial line, idle high, registered
//           busy       - high whenever a frame is being fetched or sent
//           frame_done - one-cycle pulse on the last cycle of each stop bit
//           sent_count - frames completed since reset, wraps
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           sent_count
);

  localparam int unsigned      IDX_W    = cnt_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  rd_en_q;
  logic                  done_q;
  logic                  armed_q;
  logic [15:0]           sent_count_q;

  logic bit_tick;
  logic bit_pre;
  logic baud_clr;
  logic can_req;

  // Restart the bit timer while loading so START is a full bit period.
  assign baud_clr = (state_q == ST_LOAD);
  assign can_req  = enable && !fifo_empty;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (baud_clr),
    .bit_tick_o (bit_tick),
    .bit_pre_o  (bit_pre)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      sent_count_q <= 16'd0;
    end else begin
      // armed_q holds off the first request for one edge after reset release.
      armed_q <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (armed_q && can_req) begin
            state_q <= ST_REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        ST_REQ: begin
          state_q <= ST_LOAD;
        end

        ST_LOAD: begin
          shift_q <= fifo_data;
          tx_q    <= 1'b0;
          state_q <= ST_START;
        end

        ST_START: begin
          if (bit_tick) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
            if (idx_q == IDX_LAST) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end

        ST_STOP: begin
          // Set one cycle early so the registered pulse lands on the final
          // stop cycle; the count moves together with the pulse.
          if (bit_pre) begin
            done_q       <= 1'b1;
            sent_count_q <= sent_count_q + 16'd1;
          end
          if (bit_tick) begin
            if (can_req) begin
              state_q <= ST_REQ;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with a byte scoreboard
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME_LAST = 10 * CPB - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic [15:0] sent_count;

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_WIDTH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: registered read data, one word per strobe.
  logic [7:0] fifo_mem [0:63];
  int fifo_wr = 0;
  int fifo_rd = 0;
  int rd_cnt = 0;
  int underflow = 0;

  assign fifo_empty = (fifo_wr == fifo_rd);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_wr == fifo_rd) begin
        underflow <= underflow + 1;
      end else begin
        fifo_data <= fifo_mem[fifo_rd[5:0]];
        fifo_rd   <= fifo_rd + 1;
      end
      rd_cnt <= rd_cnt + 1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] exp_q [$];
  int         mon_frames = 0;
  int         mon_gap = 0;
  int         mon_cnt = -1;
  int         mon_hi = 0;
  logic [9:0] mon_bits = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_push(input logic [7:0] b, input bit expect_sent);
    fifo_mem[fifo_wr[5:0]] = b;
    fifo_wr++;
    if (expect_sent) exp_q.push_back(b);
  endtask

  // Decodes frames from tx, samples each bit mid-period, pops the scoreboard.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_cnt = -1;
        mon_hi  = 0;
      end else begin
        if (mon_cnt < 0) begin
          if (tx == 1'b0) begin
            mon_cnt = 0;
            mon_gap = mon_hi;
          end else begin
            mon_hi++;
          end
        end else begin
          mon_cnt++;
        end
        if (frame_done) check("frame_done_at", mon_cnt, FRAME_LAST);
        if (mon_cnt >= 0 && (mon_cnt % CPB) == CPB / 2) mon_bits[mon_cnt / CPB] = tx;
        if (mon_cnt == FRAME_LAST) begin
          mon_frames++;
          check("start_bit", mon_bits[0], 0);
          check("stop_bit", mon_bits[9], 1);
          if (exp_q.size() == 0) begin
            check("sb_unexpected", mon_bits[8:1], 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", mon_bits[8:1], e);
          end
          mon_cnt = -1;
          mon_hi  = 0;
        end
      end
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && mon_frames < target; i++) @(negedge clk);
    check("frames_seen", mon_frames, target);
  endtask

  task automatic wait_tx_low(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (tx == 1'b0) seen = 1;
    end
    check("start_seen", seen, 1);
  endtask

  initial begin
    int bad;
    int rd_before;
    rst    = 1'b0;
    enable = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_done", frame_done, 0);
    check("rst_count", sent_count, 0);

    // Single frame 0xA5; request must not come on the first edge after release.
    fifo_push(8'hA5, 1);
    enable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("no_req_edge1", fifo_rd_en, 0);
    @(negedge clk);
    check("req_edge2", fifo_rd_en, 1);
    @(negedge clk);
    check("rd_en_one_cycle", fifo_rd_en, 0);
    check("busy_in_load", busy, 1);
    wait_frames(1, 200);
    check("count_1", sent_count, 1);
    repeat (3) @(negedge clk);
    check("rd_cnt_1", rd_cnt, 1);
    check("idle_busy", busy, 0);
    check("idle_tx", tx, 1);

    // Back-to-back 0x00, 0xFF.
    fifo_push(8'h00, 1);
    fifo_push(8'hFF, 1);
    wait_frames(3, 300);
    check("b2b_gap", mon_gap, 2);
    check("count_3", sent_count, 3);
    repeat (3) @(negedge clk);
    check("b2b_empty", fifo_empty, 1);
    check("rd_cnt_3", rd_cnt, 3);

    // Empty FIFO with enable high.
    bad = 0;
    rd_before = rd_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("empty_idle_cycles_bad", bad, 0);
    check("empty_no_rd", rd_cnt, rd_before);

    // Enable drop mid-DATA with more data pending.
    fifo_push(8'h3C, 1);
    fifo_push(8'h55, 0);
    wait_tx_low(50);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_frames(4, 200);
    repeat (20) @(negedge clk);
    check("drop_rd_cnt", rd_cnt, 4);
    check("drop_busy", busy, 0);
    check("drop_pending", fifo_empty, 0);
    check("count_4", sent_count, 4);

    // Reset during the third data bit of the pending 0x55.
    enable = 1'b1;
    wait_tx_low(50);
    enable = 1'b0;
    repeat (2 * CPB + CPB + 1) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", sent_count, 0);
    check("mid_rst_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_rst_frames", mon_frames, 4);
    check("mid_rst_count_after", sent_count, 0);

    // Counter wrap.
    @(negedge clk);
    force dut.sent_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.sent_count_q;
    @(negedge clk);
    check("wrap_preload", sent_count, 16'hFFFF);
    fifo_push(8'h81, 1);
    enable = 1'b1;
    wait_frames(5, 200);
    check("wrap_count", sent_count, 0);
    repeat (5) @(negedge clk);

    check("rd_underflow", underflow, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
